// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between NUM_REQ requesters.
// One request is granted at a time (round-robin by default), driven into the
// ALU for a single enable cycle, and its result is returned through a
// one-entry response buffer with valid/ready backpressure.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins, ptr held at 0
//                          undefined: round-robin starting after the last served id
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    per-requester handshake (req_ready one-hot or zero)
//   req_instr/op1/op2        per-requester instruction and operands
//   alu_instr/op1/op2        issue registers driven to the ALU
//   alu_enable               high for the single EXEC cycle
//   alu_instr_exec, alu_result  registered ALU outputs, valid in CAPT
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_result, rsp_illegal  response payload

package alu_arbiter_pkg;
    localparam int unsigned INSTR_W = 4;
    localparam int unsigned REG_W   = 32;

    typedef logic [INSTR_W-1:0] instruction_t;
    typedef logic [REG_W-1:0]   register_t;

    localparam instruction_t M_ADD = 4'h0;
    localparam instruction_t M_SUB = 4'h1;
    localparam instruction_t M_AND = 4'h2;
    localparam instruction_t M_OR  = 4'h3;
    localparam instruction_t M_XOR = 4'h4;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0][INSTR_W-1:0] req_instr,
    input  logic [NUM_REQ-1:0][REG_W-1:0]   req_op1,
    input  logic [NUM_REQ-1:0][REG_W-1:0]   req_op2,
    output logic [INSTR_W-1:0]              alu_instr,
    output logic [REG_W-1:0]                alu_op1,
    output logic [REG_W-1:0]                alu_op2,
    output logic                            alu_enable,
    input  logic                            alu_instr_exec,
    input  logic [REG_W-1:0]                alu_result,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [ID_W-1:0]                 rsp_id,
    output logic [REG_W-1:0]                rsp_result,
    output logic                            rsp_illegal
);

    // One extra bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
    localparam int unsigned IDX_W = ID_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_e;

    state_e               state_q;
    logic [ID_W-1:0]      ptr_q;
    logic [ID_W-1:0]      ptr_d;
    logic [ID_W-1:0]      cur_id_q;
    logic [INSTR_W-1:0]   instr_q;
    logic [REG_W-1:0]     op1_q;
    logic [REG_W-1:0]     op2_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [REG_W-1:0]     rsp_result_q;
    logic                 rsp_illegal_q;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_id;
    logic [IDX_W-1:0]     idx;

    // First valid requester searching upward from ptr_q with wrap-around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + IDX_W'(i);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (!grant_found && req_valid[ID_W'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: pointer never moves off requester 0.
    assign ptr_d = '0;
`else
    logic [IDX_W-1:0] id_inc;

    // Pointer moves to the requester after the one just served.
    always_comb begin
        id_inc = {1'b0, cur_id_q} + IDX_W'(1);
        ptr_d  = (id_inc == IDX_W'(NUM_REQ)) ? '0 : ID_W'(id_inc);
    end
`endif

    // Grant is only offered in IDLE and never while reset is asserted.
    assign req_ready = (!rst && (state_q == IDLE) && grant_found)
                       ? (NUM_REQ'(1) << grant_id) : '0;

    // Control FSM with issue and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cur_id_q      <= '0;
            instr_q       <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_result_q  <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        instr_q  <= req_instr[grant_id];
                        op1_q    <= req_op1[grant_id];
                        op2_q    <= req_op2[grant_id];
                        cur_id_q <= grant_id;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    state_q <= CAPT;
                end
                CAPT: begin
                    // Unexecuted opcodes return a zero result flagged illegal.
                    rsp_result_q  <= alu_instr_exec ? alu_result : '0;
                    rsp_illegal_q <= !alu_instr_exec;
                    rsp_id_q      <= cur_id_q;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_instr   = instr_q;
    assign alu_op1     = op1_q;
    assign alu_op2     = op2_q;
    assign alu_enable  = (state_q == EXEC);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single registered ALU between `NUM_REQ` requesters (issue ports, address-generation helpers, debug unit). It selects one request at a time, drives the ALU for one enable cycle and captures the registered result. It returns the result through a one-entry response buffer with valid/ready backpressure. The block sits between the issue stage and the ALU and is the only driver of the ALU's `instr`, `op1`, `op2` and `enable` inputs.

## Interface
- `NUM_REQ`, 2: number of requesters, legal 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: requester id width (derived).

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  `NUM_REQ`  request pending, one bit per requester.
- `req_ready`  out  `NUM_REQ`  request accepted this cycle (one-hot or zero).
- `req_instr`  in  `NUM_REQ` x `instruction_t`  per-requester instruction.
- `req_op1`, `req_op2`  in  `NUM_REQ` x `register_t`  per-requester operands.
- `alu_instr`  out  `instruction_t`  to ALU.
- `alu_op1`, `alu_op2`  out  `register_t`  to ALU.
- `alu_enable`  out  1  to ALU.
- `alu_instr_exec`  in  1  from ALU.
- `alu_result`  in  `register_t`  from ALU.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  `ID_W`  requester that owns the response.
- `rsp_result`  out  `register_t`  ALU result.
- `rsp_illegal`  out  1  ALU did not execute the opcode.

## Operation
- FSM states are IDLE, EXEC, CAPT, RESP.
- IDLE:
  - A grant is computed combinationally from `req_valid` and the priority pointer `ptr`.
  - The granted bit of `req_ready` is high; all others are low.
  - On handshake (`req_valid[g] & req_ready[g]`), latch instr/op1/op2 into the issue registers, latch g into `cur_id` and go to EXEC.
  - With no request pending, stay in IDLE.
- EXEC: `alu_enable`=1 (decoded from state). The ALU samples at the end of this cycle. Go to CAPT.
- CAPT:
  - `alu_result` and `alu_instr_exec` are valid. Load the response registers:
    - `rsp_result` = `alu_result` if `alu_instr_exec`=1, else 0.
    - `rsp_illegal` = !`alu_instr_exec`.
    - `rsp_id` = `cur_id`.
  - Set `rsp_valid`=1 and go to RESP.
- RESP:
  - Hold all `rsp_*` stable while `rsp_ready`=0.
  - When `rsp_ready`=1: clear `rsp_valid`, set `ptr` = (`cur_id`+1) mod `NUM_REQ` and go to IDLE.
- Round-robin grant: first requester with `req_valid` set, searching from `ptr` upward and wrapping past `NUM_REQ`-1 to 0.
- `alu_instr`/`alu_op1`/`alu_op2` are driven from the issue registers in every state. They change only on a handshake.
- Requesters hold `req_valid` and their payload stable until accepted. Dropping `req_valid` before acceptance is a protocol error; the bench never does it.
- `req_ready` is low in EXEC, CAPT and RESP. At most one request is in flight.

## Timing
- Handshake in cycle T means `alu_enable` is high in T+1, capture happens at the end of T+2, and `rsp_valid` rises in T+3.
- With `rsp_ready` held high, `rsp_valid` is high for exactly one cycle (T+3), the FSM is back in IDLE in T+4, and the next handshake can occur in T+4.
- Peak throughput is one operation per 4 cycles.
- Reset values (asynchronous):
  - State IDLE, `ptr`=0, `cur_id`=0.
  - Issue registers 0, so `alu_instr`, `alu_op1` and `alu_op2` are 0.
  - `alu_enable`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_illegal`=0.
  - `req_ready` is forced to all zeros while `rst`=1.
- Reset mid-operation (any non-IDLE state): the transaction is dropped, no response is produced and `ptr` returns to 0.
- A request arriving during RESP waits; it can be granted no earlier than the first IDLE cycle.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep `req_valid` set.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest-index valid requester wins; `ptr` is ignored and held at 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Req0 M_ADD op1=5, op2=7, `rsp_ready`=1 -> `alu_enable` in T+1; `rsp_valid` in T+3 with `rsp_id`=0, `rsp_result`=12, `rsp_illegal`=0.
- `NUM_REQ`=2, both requesters continuously valid with M_SUB 10-3 and M_XOR 0xF0^0x0F -> responses alternate id 0 (7), id 1 (0xFF), id 0, id 1. With `ALU_ARB_FIXED_PRIO_EN` -> ids are 0,0,0,0.
- `NUM_REQ`=3, sequence served 1 then 2, then all three valid -> next grant is id 0 (pointer wrap).
- Undefined opcode from req1 -> `rsp_illegal`=1, `rsp_result`=0, `rsp_id`=1.
- Response backpressure: `rsp_ready`=0 for 5 cycles after `rsp_valid`, req0 valid -> `rsp_*` stable, `req_ready`=0 throughout; req0 is accepted in the first IDLE cycle after `rsp_ready`=1.
- Assert `rst` in the EXEC cycle of an M_ADD -> no `rsp_valid` ever, all outputs at reset values immediately, next request served normally with `ptr`=0.
